// File: rtl/dds_wavetable_reader.sv
// dds_wavetable_reader: phase-accumulator driven read engine for the waveform RAM.
// Drives two adjacent table addresses (n, n+1) and captures both samples.
// Blends them linearly by the phase fraction.
// Hands one signed sample per accepted tick downstream over valid/ready.
module dds_wavetable_reader #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int PHASE_WIDTH = 24,
   parameter int FRAC_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable_i,
   input  logic                   phase_clear_i,
   input  logic [PHASE_WIDTH-1:0] tuning_word_i,
   input  logic                   sample_tick_i,
   output logic [ADDR_WIDTH-1:0]  read_addr_o1,
   output logic [ADDR_WIDTH-1:0]  read_addr_o2,
   input  logic [DATA_WIDTH-1:0]  read_data_i1,
   input  logic [DATA_WIDTH-1:0]  read_data_i2,
   output logic [DATA_WIDTH-1:0]  sample_o,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic                   busy_o,
   output logic                   overrun_o
);

   // The fraction must come from phase bits below the table index.
   generate
      if (FRAC_WIDTH > PHASE_WIDTH - ADDR_WIDTH) begin : g_frac_width_check
         $error("dds_wavetable_reader: FRAC_WIDTH must not exceed PHASE_WIDTH-ADDR_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, OUT} state_t;

   // Wide enough for sign-extended s0 plus (s1-s0)*frac without overflow.
   localparam int PROD_WIDTH = DATA_WIDTH + FRAC_WIDTH + 2;

   state_t                  state_reg;
   logic [PHASE_WIDTH-1:0]  phase_reg;
   logic [FRAC_WIDTH-1:0]   frac_reg;
   logic [ADDR_WIDTH-1:0]   addr1_reg;
   logic [ADDR_WIDTH-1:0]   addr2_reg;
   logic [DATA_WIDTH-1:0]   sample_reg;
   logic                    valid_reg;
   logic                    busy_reg;
   logic                    overrun_reg;

   logic                    tick_req;
   logic                    handshake;
   logic                    accept;
   logic                    drop;
   logic [ADDR_WIDTH-1:0]   addr_base;

   logic signed [DATA_WIDTH:0]   diff;
   logic signed [PROD_WIDTH-1:0] diff_ext;
   logic signed [PROD_WIDTH-1:0] frac_ext;
   logic signed [PROD_WIDTH-1:0] s0_ext;
   logic signed [PROD_WIDTH-1:0] prod;
   logic signed [PROD_WIDTH-1:0] interp_full;
   logic [DATA_WIDTH-1:0]        sample_next;
   logic                         interp_unused;

   // Tick acceptance: only when idle or when the current sample is being handed off.
   always_comb begin
      tick_req  = sample_tick_i & enable_i;
      handshake = valid_reg & sample_ready_i;
      accept    = tick_req & ((state_reg == IDLE) | ((state_reg == OUT) & handshake));
      drop      = tick_req & ~accept;
      addr_base = phase_reg[PHASE_WIDTH-1 -: ADDR_WIDTH];
   end

   // Interpolation s0 + ((s1-s0)*frac >>> FRAC_WIDTH); result stays between s0 and s1.
   always_comb begin
      diff = $signed({read_data_i2[DATA_WIDTH-1], read_data_i2})
           - $signed({read_data_i1[DATA_WIDTH-1], read_data_i1});
      diff_ext      = {{(FRAC_WIDTH+1){diff[DATA_WIDTH]}}, diff};
      frac_ext      = {{(DATA_WIDTH+2){1'b0}}, frac_reg};
      s0_ext        = {{(FRAC_WIDTH+2){read_data_i1[DATA_WIDTH-1]}}, read_data_i1};
      prod          = diff_ext * frac_ext;
      interp_full   = s0_ext + (prod >>> FRAC_WIDTH);
      sample_next   = interp_full[DATA_WIDTH-1:0];
      interp_unused = ^interp_full[PROD_WIDTH-1:DATA_WIDTH];
   end

   // Control FSM with phase accumulator, address/fraction latch and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         phase_reg   <= '0;
         frac_reg    <= '0;
         addr1_reg   <= '0;
         addr2_reg   <= '0;
         sample_reg  <= '0;
         valid_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         overrun_reg <= drop;

         // Clear wins over the increment; the tick still fetches with the old phase.
         if (phase_clear_i) begin
            phase_reg <= '0;
         end else if (accept) begin
            phase_reg <= phase_reg + tuning_word_i;
         end

         if (accept) begin
            addr1_reg <= addr_base;
            addr2_reg <= addr_base + ADDR_WIDTH'(1);
            frac_reg  <= phase_reg[PHASE_WIDTH-ADDR_WIDTH-1 -: FRAC_WIDTH];
         end

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  state_reg <= FETCH;
                  busy_reg  <= 1'b1;
               end
            end
            FETCH: begin
               state_reg <= CAPTURE;
            end
            CAPTURE: begin
               sample_reg <= sample_next;
               valid_reg  <= 1'b1;
               state_reg  <= OUT;
            end
            OUT: begin
               if (handshake) begin
                  valid_reg <= 1'b0;
                  if (accept) begin
                     state_reg <= FETCH;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               valid_reg <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign read_addr_o1   = addr1_reg;
   assign read_addr_o2   = addr2_reg;
   assign sample_o       = sample_reg;
   assign sample_valid_o = valid_reg;
   assign busy_o         = busy_reg;
   assign overrun_o      = overrun_reg;

endmodule

// File: tb/tb_dds_wavetable_reader.sv
// Directed testbench for dds_wavetable_reader with a 1-cycle registered-read RAM model.
module tb_dds_wavetable_reader;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int PW = 16;
   localparam int FW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable_i;
   logic          phase_clear_i;
   logic [PW-1:0] tuning_word_i;
   logic          sample_tick_i;
   logic [AW-1:0] read_addr_o1;
   logic [AW-1:0] read_addr_o2;
   logic [DW-1:0] read_data_i1;
   logic [DW-1:0] read_data_i2;
   logic [DW-1:0] sample_o;
   logic          sample_valid_o;
   logic          sample_ready_i;
   logic          busy_o;
   logic          overrun_o;

   logic [DW-1:0] ram [0:(1<<AW)-1];

   int n_checks = 0;
   int n_errors = 0;

   dds_wavetable_reader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .PHASE_WIDTH(PW),
      .FRAC_WIDTH (FW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable_i      (enable_i),
      .phase_clear_i (phase_clear_i),
      .tuning_word_i (tuning_word_i),
      .sample_tick_i (sample_tick_i),
      .read_addr_o1  (read_addr_o1),
      .read_addr_o2  (read_addr_o2),
      .read_data_i1  (read_data_i1),
      .read_data_i2  (read_data_i2),
      .sample_o      (sample_o),
      .sample_valid_o(sample_valid_o),
      .sample_ready_i(sample_ready_i),
      .busy_o        (busy_o),
      .overrun_o     (overrun_o)
   );

   always #5 clk = ~clk;

   // Waveform RAM: two registered read ports, one cycle of latency.
   always @(posedge clk) begin
      read_data_i1 <= ram[read_addr_o1];
      read_data_i2 <= ram[read_addr_o2];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One tick from IDLE with ready high; checks addresses, latency, sample and return to IDLE.
   task automatic do_tick(input string tag, input logic clr,
                          input logic [7:0] e_a1, input logic [7:0] e_a2, input logic [7:0] e_s);
      sample_tick_i = 1'b1;
      phase_clear_i = clr;
      @(negedge clk);
      sample_tick_i = 1'b0;
      phase_clear_i = 1'b0;
      check({tag, "_addr1"}, 32'(read_addr_o1), 32'(e_a1));
      check({tag, "_addr2"}, 32'(read_addr_o2), 32'(e_a2));
      check({tag, "_busy"},  32'(busy_o), 1);
      @(negedge clk);
      check({tag, "_early_valid"}, 32'(sample_valid_o), 0);
      @(negedge clk);
      check({tag, "_valid"},  32'(sample_valid_o), 1);
      check({tag, "_sample"}, 32'(sample_o), 32'(e_s));
      $display("txn %s: addr %02h/%02h sample %02h", tag, read_addr_o1, read_addr_o2, sample_o);
      @(negedge clk);
      check({tag, "_valid_drop"}, 32'(sample_valid_o), 0);
      check({tag, "_idle"},       32'(busy_o), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_valid;
      for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
      ram[0]   = 8'h81;
      ram[1]   = 8'h10;
      ram[2]   = 8'h20;
      ram[3]   = 8'h1F;
      ram[4]   = 8'h05;
      ram[5]   = 8'h0B;
      ram[6]   = 8'h33;
      ram[7]   = 8'h44;
      ram[255] = 8'h7F;

      rst_n          = 1'b0;
      enable_i       = 1'b1;
      phase_clear_i  = 1'b0;
      tuning_word_i  = 16'h0180;
      sample_tick_i  = 1'b0;
      sample_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_addr1",   32'(read_addr_o1), 0);
      check("rst_addr2",   32'(read_addr_o2), 0);
      check("rst_sample",  32'(sample_o), 0);
      check("rst_valid",   32'(sample_valid_o), 0);
      check("rst_busy",    32'(busy_o), 0);
      check("rst_overrun", 32'(overrun_o), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic interpolation with phase steps of 1.5 table entries
      do_tick("basic1", 1'b0, 8'h00, 8'h01, 8'h81);
      repeat (4) @(negedge clk);
      do_tick("basic2", 1'b0, 8'h01, 8'h02, 8'h18);
      // Negative step, then a fraction that must round toward -inf (0x20 -> 0x1F at half)
      tuning_word_i = 16'hFF80;
      do_tick("negstep", 1'b0, 8'h03, 8'h04, 8'h1F);
      do_tick("round",   1'b0, 8'h02, 8'h03, 8'h1F);

      // Wrap-around of both the table index and the accumulator
      phase_clear_i = 1'b1;
      @(negedge clk);
      phase_clear_i = 1'b0;
      do_tick("wrap0", 1'b0, 8'h00, 8'h01, 8'h81);
      do_tick("wrap1", 1'b0, 8'hFF, 8'h00, 8'h00);
      do_tick("wrap2", 1'b0, 8'hFF, 8'h00, 8'h7F);

      // Asynchronous reset in the middle of FETCH
      sample_tick_i = 1'b1;
      @(negedge clk);
      sample_tick_i = 1'b0;
      check("rstmid_fetch_addr", 32'(read_addr_o1), 32'hFE);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_addr1",  32'(read_addr_o1), 0);
      check("rstmid_addr2",  32'(read_addr_o2), 0);
      check("rstmid_sample", 32'(sample_o), 0);
      check("rstmid_valid",  32'(sample_valid_o), 0);
      check("rstmid_busy",   32'(busy_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_valid = seen_valid | sample_valid_o | busy_o;
      end
      check("rstmid_no_partial", 32'(seen_valid), 0);
      tuning_word_i = 16'h0180;

      // Backpressure: ready low for five OUT cycles, tick dropped in the third
      sample_ready_i = 1'b0;
      sample_tick_i  = 1'b1;
      @(negedge clk);
      sample_tick_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("bp_valid_c1",  32'(sample_valid_o), 1);
      check("bp_sample_c1", 32'(sample_o), 32'h81);
      @(negedge clk);
      check("bp_valid_c2",  32'(sample_valid_o), 1);
      @(negedge clk);
      sample_tick_i = 1'b1;
      @(negedge clk);
      sample_tick_i = 1'b0;
      check("bp_overrun_pulse", 32'(overrun_o), 1);
      check("bp_valid_c4",      32'(sample_valid_o), 1);
      check("bp_sample_c4",     32'(sample_o), 32'h81);
      @(negedge clk);
      check("bp_overrun_end", 32'(overrun_o), 0);
      check("bp_valid_c5",    32'(sample_valid_o), 1);
      @(negedge clk);
      sample_ready_i = 1'b1;
      @(negedge clk);
      check("bp_valid_after_hs", 32'(sample_valid_o), 0);
      check("bp_idle_after_hs",  32'(busy_o), 0);
      $display("txn backpressure: sample held at 81 until ready");
      // Dropped tick must not have advanced the phase (one step of 0x0180 so far)
      do_tick("after_ovr", 1'b0, 8'h01, 8'h02, 8'h18);

      // Back-to-back: tick coincident with the OUT handshake is accepted
      sample_tick_i = 1'b1;
      @(negedge clk);
      sample_tick_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_a_valid",  32'(sample_valid_o), 1);
      check("b2b_a_sample", 32'(sample_o), 32'h1F);
      sample_tick_i = 1'b1;
      @(negedge clk);
      sample_tick_i = 1'b0;
      check("b2b_no_overrun", 32'(overrun_o), 0);
      check("b2b_valid_drop", 32'(sample_valid_o), 0);
      check("b2b_busy",       32'(busy_o), 1);
      check("b2b_b_addr1",    32'(read_addr_o1), 32'h04);
      check("b2b_b_addr2",    32'(read_addr_o2), 32'h05);
      @(negedge clk);
      check("b2b_b_early", 32'(sample_valid_o), 0);
      @(negedge clk);
      check("b2b_b_valid",  32'(sample_valid_o), 1);
      check("b2b_b_sample", 32'(sample_o), 32'h08);
      $display("txn b2b: second sample %02h", sample_o);
      @(negedge clk);
      check("b2b_b_idle", 32'(busy_o), 0);

      // Enable low: ticks ignored, no overrun
      enable_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sample_tick_i = 1'b1;
         @(negedge clk);
         sample_tick_i = 1'b0;
         check("dis_busy",    32'(busy_o), 0);
         check("dis_overrun", 32'(overrun_o), 0);
         @(negedge clk);
      end
      enable_i = 1'b1;

      // Clear together with a tick: fetch uses old phase 0x0600, next tick phase 0
      do_tick("clr_tick", 1'b1, 8'h06, 8'h07, 8'h33);
      do_tick("post_clr", 1'b0, 8'h00, 8'h01, 8'h81);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
